// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant sequencer.
// Holds the FSM state enum, default sizes and a one-hot rotator.
package rr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int DEF_N        = 4;
   localparam int DEF_CW       = 4;
   localparam int DEF_MAX_HOLD = 8;

   // Rotate the low n bits of v left by one (n <= 32).
   function automatic logic [31:0] rotl1(
      input logic [31:0] v,
      input int unsigned n
   );
      logic [31:0] m;
      m = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
      return ((v << 1) | (v >> (n - 1))) & m;
   endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Arbiter-facing bundle: level requests in, grant and status out.
// The arbiter takes the slave side, the requester block the master side.
interface rr_grant_sequencer_if
   import rr_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int CW = DEF_CW
) ();

   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          busy;
   logic [N-1:0]  prio;
   logic [CW-1:0] grant_cnt;
   logic          timeout;

   modport master (
      output req,
      input  gnt, busy, prio, grant_cnt, timeout
   );

   modport slave (
      input  req,
      output gnt, busy, prio, grant_cnt, timeout
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or above prio,
// wrapping; the doubled vector turns the wrap into a plain carry scan.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] prio_i,
   output logic [N-1:0] gnt_o
);

   localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

   logic [2*N-1:0] dreq;
   logic [2*N-1:0] dpri;
   logic [2*N-1:0] mask;
   logic [2*N-1:0] hit;
   logic [2*N-1:0] first;

   // Mask off everything below the pointer, isolate lowest hit, fold.
   always_comb begin
      dreq  = {req_i, req_i};
      dpri  = {{N{1'b0}}, prio_i};
      mask  = ~(dpri - ONE);
      hit   = dreq & mask;
      first = hit & (~hit + ONE);
      gnt_o = first[N-1:0] | first[2*N-1:N];
   end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin owner sequencer for the shared counter/rotator datapath.
// IDLE arbitrates, BUSY holds with a timeout, GAP forces one dead cycle.
module rr_grant_sequencer
   import rr_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int CW       = DEF_CW,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input logic clk,
   input logic rst_n,
   rr_grant_sequencer_if.slave bus
);

   localparam int TW = $clog2(MAX_HOLD);
   localparam logic [TW-1:0] TLAST = TW'(MAX_HOLD - 1);

   state_e        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [N-1:0]  prio_q, prio_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          tout_q, tout_d;
   logic [N-1:0]  pick;
   logic          own_req;

   rr_pick #(.N(N)) u_pick (
      .req_i  (bus.req),
      .prio_i (prio_q),
      .gnt_o  (pick)
   );

   assign own_req = |(bus.req & gnt_q);

   // Next-state: arbitrate in IDLE, hold/release in BUSY, one GAP cycle.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      tout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = BUSY;
               gnt_d   = pick;
               tmr_d   = '0;
               prio_d  = N'(rotl1(32'(pick), N));
               cnt_d   = cnt_q + CW'(1);
            end
         end
         BUSY: begin
            if (!own_req) begin
               gnt_d   = '0;
               state_d = GAP;
            end else if (tmr_q == TLAST) begin
               gnt_d   = '0;
               tout_d  = 1'b1;
               state_d = GAP;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         prio_q  <= N'(1);
         cnt_q   <= '0;
         tmr_q   <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         tout_q  <= tout_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q == BUSY);
   assign bus.prio      = prio_q;
   assign bus.grant_cnt = cnt_q;
   assign bus.timeout   = tout_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer: directed scenarios then random traffic,
// every cycle compared against an index/counter level reference model.
module tb_rr_grant_sequencer;

   localparam int N        = 4;
   localparam int CW       = 4;
   localparam int MAX_HOLD = 8;

   logic clk;
   logic rst_n;

   rr_grant_sequencer_if #(.N(N), .CW(CW)) bus ();

   rr_grant_sequencer #(
      .N(N), .CW(CW), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 = none), cycles held, pointer index.
   int m_owner;
   int m_held;
   int m_pidx;
   int m_cnt;
   int m_cool;
   bit m_tout;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rst, input logic [N-1:0] r);
      bit found;
      if (!rst) begin
         m_owner = -1;
         m_held  = 0;
         m_pidx  = 0;
         m_cnt   = 0;
         m_cool  = 0;
         m_tout  = 0;
         return;
      end
      m_tout = 0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1;
            m_cool  = 1;
         end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_cool  = 1;
            m_tout  = 1;
         end else begin
            m_held++;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (r != '0) begin
         found = 0;
         for (int o = 0; o < N; o++) begin
            int i;
            i = (m_pidx + o) % N;
            if (!found && r[i]) begin
               found   = 1;
               m_owner = i;
            end
         end
         m_pidx = (m_owner + 1) % N;
         m_cnt  = (m_cnt + 1) % (1 << CW);
         m_held = 1;
      end
   endtask

   task automatic compare_all();
      logic [31:0] eg;
      eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      chk("gnt", 32'(bus.gnt), eg);
      chk("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("prio", 32'(bus.prio), 32'd1 << m_pidx);
      chk("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
      chk("timeout", 32'(bus.timeout), 32'(m_tout));
   endtask

   task automatic cycle(input bit rst, input logic [N-1:0] r);
      @(negedge clk);
      rst_n   = rst;
      bus.req = r;
      @(posedge clk);
      model_step(rst, r);
      #1;
      compare_all();
   endtask

   initial begin
      logic [N-1:0] rq;
      int own;
      rst_n   = 1'b0;
      bus.req = '0;

      // Reset with all requests raised.
      cycle(0, 4'b1111);
      cycle(0, 4'b1111);
      chk("rst_prio", 32'(bus.prio), 32'h1);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);

      // Single requester for three cycles.
      for (int k = 0; k < 3; k++) begin
         cycle(1, 4'b0100);
         chk("single_gnt", 32'(bus.gnt), 32'h4);
      end
      cycle(1, 4'b0000);
      chk("single_rel", 32'(bus.gnt), 32'h0);
      cycle(1, 4'b0000);
      chk("single_prio", 32'(bus.prio), 32'h8);
      chk("single_cnt", 32'(bus.grant_cnt), 32'd1);

      // Fairness with all requesting, owner drops briefly.
      cycle(0, 4'b0000);
      for (int g = 0; g < 5; g++) begin
         cycle(1, 4'b1111);
         chk("fair_order", 32'(bus.gnt), 32'd1 << (g % 4));
         cycle(1, 4'b1111);
         own = g % 4;
         rq  = 4'b1111;
         rq[own] = 1'b0;
         cycle(1, rq);
         chk("fair_gap1", 32'(bus.gnt), 32'h0);
         cycle(1, 4'b1111);
         chk("fair_gap2", 32'(bus.gnt), 32'h0);
      end

      // Forced release after MAX_HOLD cycles.
      cycle(0, 4'b0000);
      for (int k = 0; k < MAX_HOLD; k++) begin
         cycle(1, 4'b0001);
         chk("hold_gnt", 32'(bus.gnt), 32'h1);
      end
      cycle(1, 4'b0001);
      chk("to_pulse", 32'(bus.timeout), 32'h1);
      chk("to_gnt", 32'(bus.gnt), 32'h0);
      cycle(1, 4'b0001);
      chk("to_clear", 32'(bus.timeout), 32'h0);
      cycle(1, 4'b0001);
      chk("regrant", 32'(bus.gnt), 32'h1);
      chk("regrant_cnt", 32'(bus.grant_cnt), 32'd2);
      cycle(1, 4'b0000);
      cycle(1, 4'b0000);

      // Counter wrap after 16 grants.
      cycle(0, 4'b0000);
      for (int k = 0; k < 16; k++) begin
         cycle(1, 4'b0001);
         cycle(1, 4'b0000);
         cycle(1, 4'b0000);
      end
      chk("wrap_cnt", 32'(bus.grant_cnt), 32'd0);

      // Release on the same edge the timer expires.
      cycle(1, 4'b0001);
      for (int k = 0; k < MAX_HOLD - 1; k++) cycle(1, 4'b0001);
      cycle(1, 4'b0000);
      chk("simul_tout", 32'(bus.timeout), 32'h0);
      chk("simul_gnt", 32'(bus.gnt), 32'h0);
      cycle(1, 4'b0000);

      // Reset in the middle of a grant.
      cycle(0, 4'b0000);
      cycle(1, 4'b0010);
      chk("mid_gnt", 32'(bus.gnt), 32'h2);
      cycle(0, 4'b0010);
      chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
      chk("mid_rst_prio", 32'(bus.prio), 32'h1);
      chk("mid_rst_cnt", 32'(bus.grant_cnt), 32'd0);
      cycle(1, 4'b1111);
      chk("mid_resume", 32'(bus.gnt), 32'h1);

      // Random traffic with sticky requests and rare resets.
      rq = '0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
         cycle(($urandom_range(0, 79) != 0), rq);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_grant_sequencer.md
# rr_grant_sequencer

Round-robin arbiter and sequencer that shares one counter/rotator datapath among N requesters. A rotating one-hot priority register chooses the owner. An up-counter records completed grants. A hold timer forces release from a requester that holds the resource too long. It sits in front of the shared counter/shift-register resource and drives its ownership and enable.

## Interface
- N, default 4, number of requesters (≥2)
- CW, default 4, width of grant counter
- MAX_HOLD, default 8, maximum cycles a grant may be held (≥2)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  N  level request, bit i = requester i
- gnt  out  N  one-hot grant, registered, all-zero when idle
- busy  out  1  high while a grant is held
- prio  out  N  one-hot priority pointer; set bit = highest-priority requester
- grant_cnt  out  CW  number of grants issued, wraps modulo 2^CW
- timeout  out  1  one-cycle pulse on forced release

## Operation
- Reset values: state IDLE, gnt=0, busy=0, prio=1 (bit 0 highest), grant_cnt=0, timeout=0, hold timer=0.
- States:
  - IDLE: if req≠0, pick the first set req bit scanning upward (with wrap) from the prio bit. Register the gnt one-hot, go to BUSY, and clear the hold timer. If req=0, stay in IDLE.
  - BUSY: the hold timer increments each cycle.
    - If req[owner]=0, release: gnt←0, go to GAP.
    - Otherwise, if the hold timer reaches MAX_HOLD−1, force release: gnt←0, timeout←1 for one cycle, go to GAP.
    - Normal release takes precedence when both conditions hold in the same cycle; timeout stays 0.
  - GAP: exactly one cycle with gnt=0, then IDLE.
- On entry to BUSY:
  - prio ← gnt rotated left by 1, so the new owner becomes lowest priority and the next index becomes highest.
  - grant_cnt ← grant_cnt+1, wrapping from 2^CW−1 to 0.
- Requests from non-owners during BUSY/GAP are ignored until IDLE. There is no queuing or latching; req is level-sampled.
- A requester that keeps req high after a forced release competes normally. It has rotated to lowest priority, so other pending requesters win first.
- busy = (state==BUSY). gnt is non-zero iff busy.
- Reset mid-grant: rst_n=0 on any edge returns every output to its reset value on that edge, regardless of state.

## Timing
- Latency req→gnt: 1 cycle from IDLE. req high before edge k gives gnt at edge k.
- Release latency: req[owner] low before edge k gives gnt=0 after edge k.
- Maximum hold: gnt stays high for exactly MAX_HOLD cycles on forced release.
- Minimum spacing between grants: 1 gnt=0 cycle (GAP) plus 1 IDLE arbitration cycle. Back-to-back grants are therefore separated by 2 idle cycles.
- timeout coincides with the first cycle of gnt=0.
- prio and grant_cnt update on the same edge that gnt asserts.

## Structure
- Shared package `rr_pkg`: state enum (IDLE, BUSY, GAP), default parameter constants, and a rotate-left function for one-hot vectors.
- One sub-module, `rr_pick`: combinational priority picker with inputs req and prio and a one-hot output. It does a double-width scan to handle wrap.
- FSM, hold timer (width clog2(MAX_HOLD)), prio register and grant counter live in the top block.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 → gnt=0, prio=4'b0001, grant_cnt=0, busy=0, timeout=0.
- Single requester: req=4'b0100 for 3 cycles, then 0 → gnt=4'b0100 for 3 cycles, prio=4'b1000, grant_cnt=1, timeout never 1.
- Fairness: req=4'b1111 held, each owner drops req for one cycle after 2 cycles of grant, then re-raises → gnt order 0001, 0010, 0100, 1000, 0001, with 2 zero-gnt cycles between grants.
- Timeout: MAX_HOLD=8, req=4'b0001 held constant → gnt high exactly 8 cycles, then timeout=1 for 1 cycle, then gnt=4'b0001 regranted (only requester) and grant_cnt=2.
- Wrap: 16 single grants with CW=4 → grant_cnt returns to 0. Simultaneous release and timer expiry at cycle 8 → timeout stays 0.
- Reset mid-grant: rst_n=0 during BUSY with gnt=4'b0010 → next edge gnt=0, prio=4'b0001, grant_cnt=0, and arbitration resumes from bit 0.
